// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operand/issue signals and stall outputs of the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  i_rs1, i_rs2, i_rd, i_long_wb_rd;
  logic              i_use_rs1, i_use_rs2, i_is_branch, i_is_jump, i_id_valid;
  logic              i_reg_write, i_mem_read, i_is_long, i_long_wb_valid, i_mem_stall_req;
  logic              o_stall_if, o_stall_id, o_flush_id_ex, o_flush_if_id, o_long_busy;
  logic [PERF_W-1:0] o_stall_count;
  modport master (
    output i_rs1, i_rs2, i_rd, i_long_wb_rd, i_use_rs1, i_use_rs2, i_is_branch, i_is_jump,
           i_id_valid, i_reg_write, i_mem_read, i_is_long, i_long_wb_valid, i_mem_stall_req,
    input  o_stall_if, o_stall_id, o_flush_id_ex, o_flush_if_id, o_long_busy, o_stall_count
  );
  modport slave (
    input  i_rs1, i_rs2, i_rd, i_long_wb_rd, i_use_rs1, i_use_rs2, i_is_branch, i_is_jump,
           i_id_valid, i_reg_write, i_mem_read, i_is_long, i_long_wb_valid, i_mem_stall_req,
    output o_stall_if, o_stall_id, o_flush_id_ex, o_flush_if_id, o_long_busy, o_stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard for IF/ID stall and ID/EX bubble; long-op unit under HAZARD_LONG_OP_EN
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 3,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int BR_EXTRA = 1,
  parameter int PERF_W   = 32
) (
  input logic               i_clk,
  input logic               i_reset,
  hazard_scoreboard_if.slave bus
);
  localparam logic [CNT_W-1:0] L_BR  = CNT_W'(BR_EXTRA);
  localparam logic [CNT_W-1:0] L_LD  = CNT_W'(LOAD_LAT + BR_EXTRA);
  localparam logic [CNT_W-1:0] L_ALU = CNT_W'(ALU_LAT + BR_EXTRA);
  if (LOAD_LAT + BR_EXTRA >= 2**CNT_W || ALU_LAT + BR_EXTRA >= 2**CNT_W) begin : g_bad_cnt_w
    $error("hazard_scoreboard: CNT_W too narrow for configured latencies");
  end
  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [PERF_W-1:0]   r_stalls;
  logic [NUM_REGS-1:0] w_pend;
  logic [CNT_W-1:0]    w_thr;
  logic                w_haz1, w_haz2, w_long_haz, w_stall, w_issue, w_long;
`ifdef HAZARD_LONG_OP_EN
  logic [NUM_REGS-1:0] r_pend;
  assign w_pend = r_pend;
  assign w_long = bus.i_is_long;
  // pending flag per register: set when a long op issues, cleared by its writeback
  always_ff @(posedge i_clk)
    if (i_reset) r_pend <= '0;
    else for (int r = 1; r < NUM_REGS; r++)
      if (w_issue && w_long && bus.i_rd == REG_W'(r)) r_pend[r] <= 1'b1;
      else if (bus.i_long_wb_valid && bus.i_long_wb_rd == REG_W'(r)) r_pend[r] <= 1'b0;
`else
  logic w_unused;
  assign w_pend   = '0;
  assign w_long   = 1'b0;
  assign w_unused = ^{bus.i_is_long, bus.i_long_wb_valid, bus.i_long_wb_rd};
`endif
  // operand readiness: ID-stage consumers need the counter fully drained, EX consumers BR_EXTRA earlier
  always_comb begin
    w_thr      = (bus.i_is_branch | bus.i_is_jump) ? '0 : L_BR;
    w_haz1     = bus.i_use_rs1 && bus.i_rs1 != '0 && (r_cnt[bus.i_rs1] > w_thr || w_pend[bus.i_rs1]);
    w_haz2     = bus.i_use_rs2 && bus.i_rs2 != '0 && (r_cnt[bus.i_rs2] > w_thr || w_pend[bus.i_rs2]);
    w_long_haz = bus.i_id_valid && ((w_long && |w_pend) || (bus.i_reg_write && w_pend[bus.i_rd]));
    w_stall    = w_haz1 | w_haz2 | w_long_haz | bus.i_mem_stall_req;
    w_issue    = bus.i_id_valid && !w_stall && bus.i_reg_write && bus.i_rd != '0;
  end
  // issue loads a fresh latency (younger write wins), otherwise counters drain unless MEM is frozen
  always_ff @(posedge i_clk)
    if (i_reset) for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    else for (int r = 0; r < NUM_REGS; r++)
      r_cnt[r] <= (w_issue && bus.i_rd == REG_W'(r)) ? (w_long ? '0 : bus.i_mem_read ? L_LD : L_ALU)
                : (!bus.i_mem_stall_req && r_cnt[r] != '0) ? r_cnt[r] - 1'b1 : r_cnt[r];
  // saturating count of stalled cycles
  always_ff @(posedge i_clk)
    if (i_reset) r_stalls <= '0;
    else if (w_stall && !(&r_stalls)) r_stalls <= r_stalls + 1'b1;
  assign bus.o_stall_if    = w_stall & ~i_reset;
  assign bus.o_stall_id    = w_stall & ~i_reset;
  assign bus.o_flush_id_ex = w_stall & ~i_reset;
  assign bus.o_flush_if_id = 1'b0;
  assign bus.o_long_busy   = |w_pend;
  assign bus.o_stall_count = r_stalls;
endmodule
